// File: rtl/hex_to_sseg_pkg.sv
// Segment constants shared by the hex-to-seven-segment decoder.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package hex_to_sseg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [7:0] sseg_t;

  localparam seg_t SSEG_0 = 7'h40;
  localparam seg_t SSEG_1 = 7'h79;
  localparam seg_t SSEG_2 = 7'h24;
  localparam seg_t SSEG_3 = 7'h30;
  localparam seg_t SSEG_4 = 7'h19;
  localparam seg_t SSEG_5 = 7'h12;
  localparam seg_t SSEG_6 = 7'h02;
  localparam seg_t SSEG_7 = 7'h78;
  localparam seg_t SSEG_8 = 7'h00;
  localparam seg_t SSEG_9 = 7'h10;
  localparam seg_t SSEG_A = 7'h08;
  localparam seg_t SSEG_B = 7'h03;
  localparam seg_t SSEG_C = 7'h46;
  localparam seg_t SSEG_D = 7'h21;
  localparam seg_t SSEG_E = 7'h06;
  localparam seg_t SSEG_F = 7'h0E;

  localparam sseg_t SSEG_BLANK  = 8'hFF;
  localparam sseg_t SSEG_ALL_ON = 8'h00;

endpackage

// File: rtl/hex_to_sseg_lut.sv
// Combinational glyph table: hex digit to active-low {g..a} pattern.
// Letters use mixed-case glyphs A b C d E F.
module hex_to_sseg_lut
  import hex_to_sseg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = SSEG_8;
    case (hex)
      4'h0: seg = SSEG_0;
      4'h1: seg = SSEG_1;
      4'h2: seg = SSEG_2;
      4'h3: seg = SSEG_3;
      4'h4: seg = SSEG_4;
      4'h5: seg = SSEG_5;
      4'h6: seg = SSEG_6;
      4'h7: seg = SSEG_7;
      4'h8: seg = SSEG_8;
      4'h9: seg = SSEG_9;
      4'hA: seg = SSEG_A;
      4'hB: seg = SSEG_B;
      4'hC: seg = SSEG_C;
      4'hD: seg = SSEG_D;
      4'hE: seg = SSEG_E;
      4'hF: seg = SSEG_F;
      default: seg = SSEG_8;
    endcase
  end

endmodule

// File: rtl/hex_to_sseg.sv
// Registered hex digit + decimal point driver for one common-anode digit.
// Optional lamp_test port is enabled by HEX_TO_SSEG_LAMP_TEST_EN.
module hex_to_sseg
  import hex_to_sseg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef HEX_TO_SSEG_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] sseg
);

  seg_t  seg;
  sseg_t sseg_d;

  hex_to_sseg_lut u_lut (
    .hex (hex),
    .seg (seg)
  );

  always_comb begin
    sseg_d = {~dp, seg};
`ifdef HEX_TO_SSEG_LAMP_TEST_EN
    if (lamp_test) sseg_d = SSEG_ALL_ON;
`endif
  end

  // Output register keeps the pin pattern glitch-free; reset blanks the digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sseg <= SSEG_BLANK;
    else       sseg <= sseg_d;
  end

endmodule

// File: tb/tb_hex_to_sseg.sv
// Scoreboard bench for hex_to_sseg: stimulus queues expected values,
// a negedge monitor compares them against the registered output.
module tb_hex_to_sseg;

  logic       clk = 1'b0;
  logic       reset;
  logic       lamp_test;
  logic [3:0] hex;
  logic       dp;
  logic [7:0] sseg;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } ent_t;
  ent_t q[$];

  hex_to_sseg dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HEX_TO_SSEG_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .hex       (hex),
    .dp        (dp),
    .sseg      (sseg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each glyph listed as the set of lit segment letters.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg", "cdefg",
                        "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] model(input logic [3:0] h, input logic d,
                                       input logic lt);
    logic [7:0] lit;
    string      s;
    lit = '0;
    s   = glyph[h];
    for (int k = 0; k < s.len(); k++) lit[s[k] - "a"] = 1'b1;
    if (d)  lit[7] = 1'b1;
    if (lt) lit = 8'hFF;
    return ~lit;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: sseg=%02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever is due on this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL stale: entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else begin
        check("scoreboard", sseg, e.exp);
      end
    end
  end

  // Called just after a rising edge; inputs are sampled at the next one.
  task automatic drive(input logic [3:0] h, input logic d, input logic lt);
    hex = h; dp = d; lamp_test = lt;
    q.push_back('{exp: model(h, d, lt), cyc: cyc + 1});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0 pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rh;
    logic       rd, rl;
    reset = 1'b0; hex = 4'h5; dp = 1'b1; lamp_test = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 check("reset_immediate", sseg, 8'hFF);
    repeat (3) @(posedge clk);
    #1 check("reset_held", sseg, 8'hFF);

    // Startup sequence.
    reset = 1'b0;
    drive(4'h0, 1'b0, 1'b0);
    check("startup_0", sseg, 8'hC0);
    drive(4'h1, 1'b0, 1'b0);
    check("startup_1", sseg, 8'hF9);
    drive(4'h3, 1'b0, 1'b0);
    check("startup_3", sseg, 8'hB0);

    // Exhaustive sweep, both dp values.
    for (int d = 0; d < 2; d++)
      for (int h = 0; h < 16; h++) drive(4'(h), 1'(d), 1'b0);
    drive(4'h8, 1'b1, 1'b0);
    check("h8_dp1", sseg, 8'h00);
    drive(4'hF, 1'b0, 1'b0);
    check("hF_dp0", sseg, 8'h8E);

    // Latency: mid-cycle change is invisible until the next edge.
    drive(4'h2, 1'b0, 1'b0);
    hex = 4'hE;
    q.push_back('{exp: 8'h86, cyc: cyc + 1});
    #2 check("latency_hold", sseg, 8'hA4);
    @(posedge clk); #1;
    check("latency_after", sseg, 8'h86);

    // Reset mid-stream.
    drive(4'h8, 1'b0, 1'b0);
    #6 reset = 1'b1;
    #1 check("reset_mid", sseg, 8'hFF);
    @(posedge clk); #1;
    check("reset_mid_held", sseg, 8'hFF);
    rh = 4'($urandom_range(0, 15)); rd = 1'($urandom_range(0, 1));
    reset = 1'b0;
    drive(rh, rd, 1'b0);
    check("reset_release", sseg, model(rh, rd, 1'b0));

`ifdef HEX_TO_SSEG_LAMP_TEST_EN
    drive(4'h1, 1'b0, 1'b1);
    check("lamp_on", sseg, 8'h00);
    drive(4'h1, 1'b0, 1'b0);
    check("lamp_off", sseg, 8'hF9);
`endif

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      rh = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
`ifdef HEX_TO_SSEG_LAMP_TEST_EN
      rl = ($urandom_range(0, 7) == 0);
`else
      rl = 1'b0;
`endif
      drive(rh, rd, rl);
    end

    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
